// File: rtl/rv_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory handshake, redirect input and decode window.
// "master" is the environment (core + memory); "slave" is the queue itself.
interface rv_fetch_queue_if #(
  parameter int unsigned FETCH_BYTES   = 8,
  parameter int unsigned WINDOW_HALVES = 4
);
  localparam int unsigned AW = 64 - $clog2(FETCH_BYTES);
  localparam int unsigned HW = $clog2(WINDOW_HALVES + 1);

  logic                         redirect;
  logic [62:0]                  redirect_pc;
  logic                         fetch_req;
  logic [AW-1:0]                fetch_addr;
  logic                         fetch_ack;
  logic [FETCH_BYTES*8-1:0]     fetch_data;
  logic                         fetch_fault;
  logic [HW-1:0]                out_halves;
  logic [62:0]                  out_pc;
  logic [WINDOW_HALVES*16-1:0]  out_window;
  logic                         out_fault;
  logic                         consume;
  logic [HW-1:0]                consume_halves;

  modport master (
    output redirect, redirect_pc, fetch_ack, fetch_data, fetch_fault,
           consume, consume_halves,
    input  fetch_req, fetch_addr, out_halves, out_pc, out_window, out_fault
  );

  modport slave (
    input  redirect, redirect_pc, fetch_ack, fetch_data, fetch_fault,
           consume, consume_halves,
    output fetch_req, fetch_addr, out_halves, out_pc, out_window, out_fault
  );
endinterface

// File: rtl/rv_fetch_queue.sv
// Instruction prefetch queue: fetches aligned blocks into a circular buffer of
// 16-bit parcels and presents a WINDOW_HALVES-parcel window at the current PC.
module rv_fetch_queue #(
  parameter int unsigned FETCH_BYTES   = 8,
  parameter int unsigned DEPTH_HALVES  = 16,
  parameter int unsigned WINDOW_HALVES = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  rv_fetch_queue_if.slave   bus
);
  localparam int unsigned OFF_W  = $clog2(FETCH_BYTES);
  localparam int unsigned AW     = 64 - OFF_W;
  localparam int unsigned BLK_H  = FETCH_BYTES / 2;
  localparam int unsigned SKIP_W = OFF_W - 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH_HALVES);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HW     = $clog2(WINDOW_HALVES + 1);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t               state;
  logic [15:0]          mem [DEPTH_HALVES];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic [AW-1:0]        fetch_pc;
  logic [SKIP_W-1:0]    skip;
  logic [62:0]          pc;
  logic                 fetch_req_q;
  logic                 fault_q;

  logic                 xfer;
  logic                 push_ok;
  logic                 pop_ok;
  logic [CNT_W-1:0]     push_n;
  logic [CNT_W-1:0]     pop_n;
  logic [CNT_W-1:0]     count_nxt;
  state_t               state_nxt;
  logic [HW-1:0]        avail;
  logic [WINDOW_HALVES*16-1:0] window;

  // Transfer/pop qualification and next count/state; redirect overrides everything.
  always_comb begin
    avail     = (count >= CNT_W'(WINDOW_HALVES)) ? HW'(WINDOW_HALVES) : HW'(count);
    xfer      = fetch_req_q & bus.fetch_ack & ~bus.redirect;
    push_ok   = xfer & ~bus.fetch_fault;
    push_n    = push_ok ? (CNT_W'(BLK_H) - CNT_W'(skip)) : '0;
    pop_ok    = bus.consume & ~bus.redirect & (bus.consume_halves != '0) &
                (bus.consume_halves <= avail);
    pop_n     = pop_ok ? CNT_W'(bus.consume_halves) : '0;
    count_nxt = bus.redirect ? '0 : (count - pop_n + push_n);
    state_nxt = state;
    if (bus.redirect)
      state_nxt = RUN;
    else if (state == RUN && xfer && bus.fetch_fault)
      state_nxt = FAULT;
  end

  // Control state; fetch_req/out_fault are registered from the next state and count,
  // which equals evaluating them each cycle on the registered count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      fetch_pc    <= '0;
      skip        <= '0;
      pc          <= '0;
      fetch_req_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      fetch_req_q <= (state_nxt == RUN) &&
                     ((CNT_W'(DEPTH_HALVES) - count_nxt) >= CNT_W'(BLK_H));
      fault_q     <= (state_nxt == FAULT);
      if (bus.redirect) begin
        head     <= '0;
        tail     <= '0;
        pc       <= bus.redirect_pc;
        fetch_pc <= bus.redirect_pc[62:OFF_W-1];
        skip     <= bus.redirect_pc[SKIP_W-1:0];
      end else begin
        head <= head + PTR_W'(pop_n);
        tail <= tail + PTR_W'(push_n);
        pc   <= pc + 63'(pop_n);
        if (push_ok) begin
          fetch_pc <= fetch_pc + 1'b1;
          skip     <= '0;
        end
      end
    end
  end

  // Parcel storage: parcels skip..BLK_H-1 of an accepted block land at tail onward.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH_HALVES; i++) mem[i] <= '0;
    end else begin
      for (int unsigned j = 0; j < BLK_H; j++) begin
        if (push_ok && SKIP_W'(j) >= skip)
          mem[tail + PTR_W'(j) - PTR_W'(skip)] <= bus.fetch_data[j*16 +: 16];
      end
    end
  end

  // Decode window read from head with wrap; slots beyond count read as zero.
  always_comb begin
    window = '0;
    for (int unsigned i = 0; i < WINDOW_HALVES; i++) begin
      if (CNT_W'(i) < count)
        window[i*16 +: 16] = mem[head + PTR_W'(i)];
    end
  end

  assign bus.fetch_req  = fetch_req_q;
  assign bus.fetch_addr = fetch_pc;
  assign bus.out_halves = avail;
  assign bus.out_pc     = pc;
  assign bus.out_window = window;
  assign bus.out_fault  = fault_q;
endmodule
